// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Holds a small program memory and issues its instructions one at a time to a
// processor. Every instruction is fetched into a register, issued with a
// one-cycle strobe, and then the sequencer waits for the processor to report
// completion. If completion takes too long the sequencer stops in an error
// state until a new start is given.
//
// Parameters
//   DEPTH    program memory entries (power of two, 2..256)
//   TIMEOUT  WAIT cycles allowed for done before flagging an error (2..255)
//
// Ports
//   clock      single clock, all state changes on its rising edge
//   resetn     asynchronous active-low reset (program memory is not cleared)
//   wr_en      program-memory write strobe, honoured only in IDLE
//   wr_addr    write address
//   wr_data    instruction word to store
//   prog_len   instructions to issue, sampled when start is accepted
//   start      begin issuing from address 0 (IDLE), or leave ERROR
//   done       processor completion for the instruction in flight
//   iin        registered instruction word to the processor
//   run        one-cycle issue strobe
//   pc         address of the instruction currently held in iin
//   busy       high in every state except IDLE and ERROR
//   finished   one-cycle pulse when the program completes
//   error      high while in ERROR
//   state_dbg  current FSM state encoding, for observation only
//
// Handshake: run is a one-cycle strobe and the processor captures iin in the
// cycle run=1. The sequencer then holds iin and pc stable and waits; done is
// looked at only in WAIT, where a single cycle of done=1 completes the
// instruction. done at any other time has no effect.
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [LW-1:0] prog_len,
  input  logic          start,
  input  logic          done,
  output logic [15:0]   iin,
  output logic          run,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          finished,
  output logic          error,
  output logic [2:0]    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t        state;
  logic [LW-1:0] len;
  logic [7:0]    cnt;
  logic [15:0]   mem [DEPTH];

  // Program memory has no reset so a loaded program survives a reset.
  // Writes land at the same edge that may accept start, so FETCH already
  // sees the new word.
  always_ff @(posedge clock) begin
    if (state == S_IDLE && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      iin   <= '0;
      pc    <= '0;
      len   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (prog_len == '0) begin
              state <= S_FINISH;
            end else begin
              // Clamp so pc never has to go past DEPTH-1.
              len   <= (prog_len > LW'(DEPTH)) ? LW'(DEPTH) : prog_len;
              pc    <= '0;
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          iin   <= mem[pc];
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (done) begin
            if ({1'b0, pc} == len - LW'(1)) begin
              state <= S_FINISH;
            end else begin
              pc    <= pc + AW'(1);
              state <= S_FETCH;
            end
          end else begin
            // cnt counts WAIT cycles already spent; this cycle is number
            // cnt+1, so TIMEOUT-1 here means the budget is used up.
            cnt <= cnt + 8'd1;
            if (cnt == 8'(TIMEOUT - 1)) begin
              state <= S_ERROR;
            end
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        S_ERROR: begin
          if (start) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // All status outputs are pure decodes of the state register.
  assign run       = (state == S_ISSUE);
  assign finished  = (state == S_FINISH);
  assign error     = (state == S_ERROR);
  assign busy      = (state != S_IDLE) && (state != S_ERROR);
  assign state_dbg = state;

endmodule
